// File: rtl/hex_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_disp_pkg
//  Description : Shared constants and hex-to-7-segment lookup for the
//                multiplexed display driver.
//  Revision    : 1.0  initial release
// ============================================================================
package hex_disp_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-high "nothing lit" values; pin polarity is applied downstream.
    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [3:0] DIG_NONE = 4'h0;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        logic [6:0] segs;
        case (nibble)
            4'h0:    segs = 7'h3F;
            4'h1:    segs = 7'h06;
            4'h2:    segs = 7'h5B;
            4'h3:    segs = 7'h4F;
            4'h4:    segs = 7'h66;
            4'h5:    segs = 7'h6D;
            4'h6:    segs = 7'h7D;
            4'h7:    segs = 7'h07;
            4'h8:    segs = 7'h7F;
            4'h9:    segs = 7'h6F;
            4'hA:    segs = 7'h77;
            4'hB:    segs = 7'h7C;
            4'hC:    segs = 7'h39;
            4'hD:    segs = 7'h5E;
            4'hE:    segs = 7'h79;
            default: segs = 7'h71;
        endcase
        return segs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex7seg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : hex7seg_decode
//  Description : Combinational nibble-to-segment decoder with blanking and
//                selectable pin polarity.
//  Revision    : 1.0  initial release
// ============================================================================
module hex7seg_decode
    import hex_disp_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] w_seg_hi;

    // Decode, force dark when blanked, then apply pin polarity.
    always_comb begin
        w_seg_hi = blank_i ? SEG_OFF : hex7(nibble_i);
        seg_o    = ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
    end

endmodule
`default_nettype wire

// File: rtl/hex_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scan_driver
//  Description : 4-digit multiplexed 7-segment scan driver with per-slot
//                anti-ghost blanking, frame-synchronous input capture and
//                per-digit blink. All pin outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_scan_driver
    import hex_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLANK_CYC      = 500,
    parameter int unsigned BLINK_DIV      = 25000000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic [3:0]  blink_en,
    input  logic [3:0]  dp_en,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig_sel,
    output logic        frame_tick
);

    localparam int PRE_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYC);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_PIN_OFF = SEG_ACTIVE_LOW ? ~SEG_OFF  : SEG_OFF;
    localparam logic       DP_PIN_OFF  = SEG_ACTIVE_LOW;
    localparam logic [3:0] DIG_PIN_OFF = DIG_ACTIVE_LOW ? ~DIG_NONE : DIG_NONE;

    // State registers and their next-state values
    logic [PRE_W-1:0] pre_q,       pre_d;
    logic [1:0]       idx_q,       idx_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_ph_q,  blink_ph_d;
    logic [15:0]      sh_value_q,  sh_value_d;
    logic [3:0]       sh_blink_q,  sh_blink_d;
    logic [3:0]       sh_dp_q,     sh_dp_d;
    // Set by the first frame capture; keeps the pins dark until real data exists.
    logic             armed_q,     armed_d;
    logic             frame_d;

    // Output-path combinational values
    logic             w_tick;
    logic             w_lit;
    logic             w_blank_seg;
    logic [3:0]       w_nibble;
    logic [3:0]       w_dig_hi;
    logic             w_dp_hi;
    logic [6:0]       w_seg_pin;

    // Next-state for prescaler, digit index, blink counter and shadow capture.
    always_comb begin
        pre_d       = pre_q;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        sh_value_d  = sh_value_q;
        sh_blink_d  = sh_blink_q;
        sh_dp_d     = sh_dp_q;
        armed_d     = armed_q;
        frame_d     = 1'b0;
        w_tick      = (pre_q == PRE_LAST) && enable;

        if (enable) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;

            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        if (w_tick) begin
            idx_d = idx_q + 2'd1;
            // The 3->0 wrap starts a frame: sample inputs once so a frame never tears.
            if (idx_q == 2'd3) begin
                sh_value_d = value;
                sh_blink_d = blink_en;
                sh_dp_d    = dp_en;
                armed_d    = 1'b1;
                frame_d    = 1'b1;
            end
        end
    end

    // Output values derived from next-state so pins move on the same edge as idx.
    always_comb begin
        w_lit       = enable && armed_d && (pre_d >= PRE_BLANK);
        w_blank_seg = !w_lit || (blink_ph_d && sh_blink_d[idx_d]);
        w_nibble    = sh_value_d[{idx_d, 2'b00} +: 4];
        w_dig_hi    = w_lit ? (4'b0001 << idx_d) : DIG_NONE;
        w_dp_hi     = !w_blank_seg && sh_dp_d[idx_d];
    end

    hex7seg_decode #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_decode (
        .nibble_i (w_nibble),
        .blank_i  (w_blank_seg),
        .seg_o    (w_seg_pin)
    );

    // State and registered pin outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q       <= '0;
            idx_q       <= 2'd3;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            sh_value_q  <= '0;
            sh_blink_q  <= '0;
            sh_dp_q     <= '0;
            armed_q     <= 1'b0;
            seg         <= SEG_PIN_OFF;
            dp          <= DP_PIN_OFF;
            dig_sel     <= DIG_PIN_OFF;
            frame_tick  <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            sh_value_q  <= sh_value_d;
            sh_blink_q  <= sh_blink_d;
            sh_dp_q     <= sh_dp_d;
            armed_q     <= armed_d;
            seg         <= w_seg_pin;
            dp          <= SEG_ACTIVE_LOW ? ~w_dp_hi : w_dp_hi;
            dig_sel     <= DIG_ACTIVE_LOW ? ~w_dig_hi : w_dig_hi;
            frame_tick  <= frame_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_scan_driver
//  Description : Scoreboard bench for hex_scan_driver with a cycle-count
//                reference model (SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64,
//                active-low pins).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hex_scan_driver;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BD = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] value;
    logic [3:0]  blink_en;
    logic [3:0]  dp_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_sel;
    logic        frame_tick;

    always #5 clk = ~clk;

    hex_scan_driver #(
        .SCAN_DIV       (SD),
        .BLANK_CYC      (BC),
        .BLINK_DIV      (BD),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .blink_en   (blink_en),
        .dp_en      (dp_en),
        .seg        (seg),
        .dp         (dp),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];
    int   tests   = 0;
    int   fails   = 0;
    bit   started = 1'b0;
    bit   done    = 1'b0;

    // Reference model: n = enabled clock edges since reset.
    int          n     = 0;
    bit          armed = 1'b0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_blk = '0;
    logic [3:0]  m_dp  = '0;

    function automatic logic [6:0] ref_hex(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    function automatic int m_idx();
        return (3 + n / SD) % 4;
    endfunction

    function automatic int m_ph();
        return (n / BD) % 2;
    endfunction

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic drive(input bit r, input bit e, input logic [15:0] v,
                         input logic [3:0] b, input logic [3:0] d);
        exp_t       x;
        int         id;
        bit         lit;
        bit         dark;
        logic [6:0] sh;
        @(negedge clk);
        reset = r; enable = e; value = v; blink_en = b; dp_en = d;
        x = '{seg: 7'h7F, dp: 1'b1, dig: 4'hF, ft: 1'b0};
        if (r) begin
            n = 0; armed = 0; m_val = '0; m_blk = '0; m_dp = '0;
        end else if (e) begin
            n = n + 1;
            if ((n % SD) == 0 && m_idx() == 0) begin
                m_val = v; m_blk = b; m_dp = d; armed = 1; x.ft = 1'b1;
            end
            id   = m_idx();
            lit  = armed && ((n % SD) >= BC);
            dark = !lit || (m_ph() == 1 && m_blk[id]);
            sh   = dark ? 7'h00 : ref_hex(m_val[id*4 +: 4]);
            x.seg = ~sh;
            x.dp  = ~(!dark && m_dp[id]);
            x.dig = lit ? ~(4'b0001 << id) : 4'hF;
        end
        exp_q.push_back(x);
        started = 1'b1;
    endtask

    // Monitor: compare DUT pins against the next queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (done) break;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                tests++;
                if ({seg, dp, dig_sel, frame_tick} !== x) begin
                    fails++;
                    $display("FAIL pins t=%0t: got seg=%h dp=%b dig=%h ft=%b, want seg=%h dp=%b dig=%h ft=%b",
                             $time, seg, dp, dig_sel, frame_tick, x.seg, x.dp, x.dig, x.ft);
                end
            end else if (started) begin
                tests++;
                fails++;
                $display("FAIL queue t=%0t: got no expectation, want one per cycle", $time);
            end
        end
    end

    initial begin
        logic [15:0] rv;
        logic [3:0]  rb, rd;
        int          k;
        reset = 1'b1; enable = 1'b1; value = 16'h1234; blink_en = '0; dp_en = '0;

        // T1: reset then first frame
        repeat (3) drive(1, 1, 16'h1234, 4'h0, 4'h0);
        repeat (80) drive(0, 1, 16'h1234, 4'h0, 4'h0);

        // T2: scan order
        repeat (100) drive(0, 1, 16'hA5F0, 4'h0, 4'h0);

        // T3: change input mid-frame
        k = 0;
        do begin drive(0, 1, 16'h1111, 4'h0, 4'h0); k++; end
        while (!(m_idx() == 1 && armed && m_val == 16'h1111) && k < 200);
        repeat (60) drive(0, 1, 16'h2222, 4'h0, 4'h0);

        // T4: blink digit 2
        repeat (300) drive(0, 1, 16'h8C3E, 4'b0100, 4'b0100);

        // T5: enable pause mid-slot
        k = 0;
        do begin drive(0, 1, 16'h4D7B, 4'b0010, 4'b1001); k++; end
        while ((n % SD) != 4 && k < 20);
        repeat (20) drive(0, 0, 16'h4D7B, 4'b0010, 4'b1001);
        repeat (40) drive(0, 1, 16'h4D7B, 4'b0010, 4'b1001);

        // T6: reset while idx=2 and blink phase 1
        k = 0;
        do begin drive(0, 1, 16'h9F06, 4'b1111, 4'b0101); k++; end
        while (!(m_idx() == 2 && m_ph() == 1) && k < 300);
        drive(1, 1, 16'h1234, 4'h0, 4'h0);
        repeat (80) drive(0, 1, 16'h1234, 4'h0, 4'h0);

        // Random soak
        for (int i = 0; i < 1500; i++) begin
            rv = 16'($urandom);
            rb = 4'($urandom);
            rd = 4'($urandom);
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) != 0), rv, rb, rd);
        end

        @(posedge clk);
        #2;
        done = 1'b1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
